// File: rtl/pio_pkg.sv
// Shared constants, register map and types for the PIO state-machine sequencer.
package pio_pkg;

  localparam int NUM_SM    = 4;
  localparam int MEM_DEPTH = 32;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_STATUS   = 6'h01;
  localparam logic [5:0] ADDR_SM_INSTR = 6'h04;
  localparam logic [5:0] ADDR_IMEM     = 6'h20;

  localparam int CTRL_EN_LSB          = 0;
  localparam int CTRL_RESTART_LSB     = 4;
  localparam int CTRL_DIV_RESTART_LSB = 8;
  localparam int STATUS_PEND_LSB      = 0;
  localparam int STATUS_EN_LSB        = 4;

  typedef logic [15:0] instr_t;

  typedef enum logic {
    IMM_IDLE = 1'b0,
    IMM_PEND = 1'b1
  } imm_state_e;

endpackage

// File: rtl/pio_imem.sv
// Shared instruction memory: one host write port, one combinational fetch port per machine
// plus one host read port. Reset clears every word to JMP 0.
module pio_imem #(
  parameter int NUM_SM    = 4,
  parameter int MEM_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [4:0]              wr_addr,
  input  logic [15:0]             wr_data,
  input  logic [NUM_SM-1:0][4:0]  rd_addr,
  output logic [NUM_SM-1:0][15:0] rd_data,
  input  logic [4:0]              host_addr,
  output logic [15:0]             host_data
);
  import pio_pkg::*;

  instr_t mem_q [MEM_DEPTH];
  instr_t mem_d [MEM_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_SM; n++) rd_data[n] = mem_q[rd_addr[n]];
    host_data = mem_q[host_addr];
  end

endmodule

// File: rtl/pio_sm_sequencer.sv
// PIO block controller: instruction memory ownership, enable/restart sequencing and
// scheduling of host-injected immediate instructions onto each machine's divided-clock tick.
module pio_sm_sequencer #(
  parameter int NUM_SM    = 4,
  parameter int MEM_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_wr,
  input  logic                    host_rd,
  input  logic [5:0]              host_addr,
  input  logic [31:0]             host_wdata,
  output logic [31:0]             host_rdata,
  output logic                    host_ready,
  input  logic [NUM_SM-1:0][4:0]  sm_pc,
  input  logic [NUM_SM-1:0]       sm_penable,
  output logic [NUM_SM-1:0][15:0] sm_instr,
  output logic [NUM_SM-1:0]       sm_imm,
  output logic [NUM_SM-1:0]       sm_en,
  output logic [NUM_SM-1:0]       sm_restart,
  output logic [NUM_SM-1:0]       sm_div_restart
);
  import pio_pkg::*;

  logic                    is_ctrl, is_status, is_instr, is_imem;
  logic [1:0]              sm_sel;
  logic [NUM_SM-1:0]       pend, busy, accept, restart_wr, div_restart_wr;
  logic [NUM_SM-1:0][15:0] imm_val, imem_rd;
  logic [15:0]             imem_host;
  logic [NUM_SM-1:0]       en_q, en_d, restart_q, restart_d, div_restart_q, div_restart_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    unused_wdata;

  assign unused_wdata = ^host_wdata[31:16];

  // A write to a machine's injection register stalls only while that machine is still
  // waiting for its execute tick; the tick cycle itself lets the new write through.
  always_comb begin
    sm_sel     = host_addr[1:0];
    is_ctrl    = (host_addr == ADDR_CTRL);
    is_status  = (host_addr == ADDR_STATUS);
    is_instr   = (host_addr[5:2] == ADDR_SM_INSTR[5:2]) && (int'(sm_sel) < NUM_SM);
    is_imem    = host_addr[5];
    busy       = pend & ~sm_penable;
    host_ready = !(host_wr && is_instr && busy[sm_sel]);
    restart_wr     = '0;
    div_restart_wr = '0;
    if (host_wr && is_ctrl) begin
      restart_wr     = host_wdata[CTRL_RESTART_LSB +: NUM_SM];
      div_restart_wr = host_wdata[CTRL_DIV_RESTART_LSB +: NUM_SM];
    end
    for (int n = 0; n < NUM_SM; n++) begin
      accept[n] = host_wr && host_ready && is_instr && (int'(sm_sel) == n);
    end
  end

  always_comb begin
    en_d          = en_q;
    restart_d     = restart_wr;
    div_restart_d = div_restart_wr;
    rdata_d       = rdata_q;
    if (host_wr && is_ctrl) en_d = host_wdata[CTRL_EN_LSB +: NUM_SM];
    if (host_rd) begin
      rdata_d = '0;
      if (is_ctrl) begin
        rdata_d[CTRL_EN_LSB +: NUM_SM] = en_q;
      end else if (is_status) begin
        rdata_d[STATUS_PEND_LSB +: NUM_SM] = pend;
        rdata_d[STATUS_EN_LSB +: NUM_SM]   = sm_en;
      end else if (is_instr) begin
        rdata_d[15:0] = imm_val[sm_sel];
      end else if (is_imem) begin
        rdata_d[15:0] = imem_host;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q          <= '0;
      restart_q     <= '0;
      div_restart_q <= '0;
      rdata_q       <= '0;
    end else begin
      en_q          <= en_d;
      restart_q     <= restart_d;
      div_restart_q <= div_restart_d;
      rdata_q       <= rdata_d;
    end
  end

  pio_imem #(
    .NUM_SM    (NUM_SM),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_imem (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (host_wr && is_imem),
    .wr_addr   (host_addr[4:0]),
    .wr_data   (host_wdata[15:0]),
    .rd_addr   (sm_pc),
    .rd_data   (imem_rd),
    .host_addr (host_addr[4:0]),
    .host_data (imem_host)
  );

  for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
    imm_state_e state_q, state_d;
    instr_t     imm_q, imm_d;

    // Restart wins over everything and abandons a pending injection.
    always_comb begin
      state_d = state_q;
      imm_d   = imm_q;
      if (restart_wr[g]) begin
        state_d = IMM_IDLE;
      end else if (accept[g]) begin
        state_d = IMM_PEND;
        imm_d   = host_wdata[15:0];
      end else if (state_q == IMM_PEND && sm_penable[g]) begin
        state_d = IMM_IDLE;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IMM_IDLE;
        imm_q   <= '0;
      end else begin
        state_q <= state_d;
        imm_q   <= imm_d;
      end
    end

    assign pend[g]     = (state_q == IMM_PEND);
    assign imm_val[g]  = imm_q;
    assign sm_instr[g] = pend[g] ? imm_q : imem_rd[g];
  end

  assign sm_imm         = pend;
  assign sm_en          = en_q | pend;
  assign sm_restart     = restart_q;
  assign sm_div_restart = div_restart_q;
  assign host_rdata     = rdata_q;

endmodule
